// File: rtl/kgp_alu_pkg.sv
// Shared definitions for the KGPminiRISC ALU execute stage:
// default widths, operation codes and the sequencer state type.
package kgp_alu_pkg;

  localparam int unsigned AluWidth = 32;
  localparam int unsigned AluShw   = 5;

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpComp = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0010;
  localparam logic [3:0] OpXor  = 4'b0011;
  localparam logic [3:0] OpSll  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSra  = 4'b0110;

  typedef enum logic {StIdle, StShift} alu_state_e;

  function automatic logic is_shift(logic [3:0] op);
    return (op == OpSll) || (op == OpSrl) || (op == OpSra);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational one-bit shifter used by the multi-cycle shift datapath.
// Reports the bit that falls off so the caller can latch it as carry.
module alu_shift_step
  import kgp_alu_pkg::*;
#(
  parameter int unsigned Width = AluWidth
) (
  input  logic [Width-1:0] value_i,
  input  logic [3:0]       mode_i,
  output logic [Width-1:0] next_o,
  output logic             out_bit_o
);

  always_comb begin
    next_o    = value_i;
    out_bit_o = 1'b0;
    case (mode_i)
      OpSll: begin
        next_o    = {value_i[Width-2:0], 1'b0};
        out_bit_o = value_i[Width-1];
      end
      OpSrl: begin
        next_o    = {1'b0, value_i[Width-1:1]};
        out_bit_o = value_i[0];
      end
      OpSra: begin
        next_o    = {value_i[Width-1], value_i[Width-1:1]};
        out_bit_o = value_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU execute stage: single-cycle logic/arithmetic ops and
// bit-serial shifts under a start/busy/done handshake.
module alu_seq
  import kgp_alu_pkg::*;
#(
  parameter int unsigned WIDTH = AluWidth,
  parameter int unsigned SHW   = AluShw
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             sign,
  output logic             busy,
  output logic             done
);

  alu_state_e       state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             sign_q, sign_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum, comp;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_valid;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] shift_next;
  logic             shift_out;

  assign amt  = b[SHW-1:0];
  assign sum  = {1'b0, a} + {1'b0, b};
  assign comp = {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_valid = 1'b1;
    case (alu_op)
      OpAdd:  begin alu_res = sum[WIDTH-1:0];  alu_carry = sum[WIDTH];  end
      OpComp: begin alu_res = comp[WIDTH-1:0]; alu_carry = comp[WIDTH]; end
      OpAnd:  alu_res = a & b;
      OpXor:  alu_res = a ^ b;
      default: alu_valid = 1'b0;
    endcase
  end

  alu_shift_step #(
    .Width (WIDTH)
  ) u_shift_step (
    .value_i   (sreg_q),
    .mode_i    (op_q),
    .next_o    (shift_next),
    .out_bit_o (shift_out)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sreg_d   = sreg_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    sign_d   = sign_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_d = alu_op;
          if (is_shift(alu_op)) begin
            if (amt == '0) begin
              result_d = a;
              carry_d  = 1'b0;
              zero_d   = (a == '0);
              sign_d   = a[WIDTH-1];
              done_d   = 1'b1;
            end else begin
              sreg_d  = a;
              cnt_d   = amt;
              state_d = StShift;
            end
          end else begin
            // Undefined codes report all-zero flags, including zero.
            result_d = alu_res;
            carry_d  = alu_carry;
            zero_d   = alu_valid && (alu_res == '0);
            sign_d   = alu_res[WIDTH-1];
            done_d   = 1'b1;
          end
        end
      end
      StShift: begin
        sreg_d = shift_next;
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d = shift_next;
          carry_d  = shift_out;
          zero_d   = (shift_next == '0);
          sign_d   = shift_next[WIDTH-1];
          done_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= OpAdd;
      sreg_q   <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sreg_q   <= sreg_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign carry  = carry_q;
  assign zero   = zero_q;
  assign sign   = sign_q;
  assign busy   = (state_q == StShift);
  assign done   = done_q;

endmodule

// File: doc/alu_seq.md
# alu_seq

Sequential ALU execute stage for the KGPminiRISC datapath. It consumes rs from the register file as operand `a` and the ALU-source mux output (register rt or sign-extended immediate) as operand `b`. It produces a registered result and flags for the writeback/branch logic. Logic and arithmetic ops finish in one cycle; shifts run one bit per cycle under a start/busy/done handshake so the control FSM can stall.

## Interface
- WIDTH, 32, datapath width
- SHW, 5, shift-amount width (log2 WIDTH)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  issue request; sampled only when `busy`=0
- alu_op  input  4  operation code (package constants)
- a  input  WIDTH  operand A (rs)
- b  input  WIDTH  operand B (ALU-source mux output); for shifts `b[SHW-1:0]` is the amount
- result  output  WIDTH  registered result; held until next completion
- carry  output  1  carry flag
- zero  output  1  result==0
- sign  output  1  result[WIDTH-1]
- busy  output  1  shift in progress; `start` ignored
- done  output  1  one-cycle completion pulse

## Operation
- Ops: ADD=0000 (a+b), COMP=0001 (~b+1), AND=0010, XOR=0011, SLL=0100, SRL=0101, SRA=0110. All other codes: result 0, flags 0, `done` still pulses.
- FSM states: IDLE, SHIFT.
- IDLE: on `start`, `alu_op`, `a` and the shift amount are latched. Later changes on `a`/`b` have no effect.
- Non-shift op: result and flags are written on the start edge, `done`=1, and the FSM stays in IDLE.
- Shift with amt=0: result=a, carry=0, `done`=1, and the FSM stays in IDLE.
- Shift with amt>0: result←a, cnt←amt, go to SHIFT.
- SHIFT: each edge shifts result by one bit and decrements cnt.
  - SLL/SRL fill with 0; SRA fills with the MSB.
  - carry ← the bit shifted out.
  - When cnt goes 1→0: `done`=1, then IDLE.
- Flags:
  - ADD: carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - COMP: carry = carry-out of ~b+1 (1 only when b==0).
  - AND/XOR: carry=0.
  - zero and sign always track the final result. Flags are updated only on completion and held otherwise.
- Arithmetic wraps modulo 2^WIDTH; no overflow flag.
- `start` while `busy`: ignored, with no queueing.
- `start` in the cycle `done` is high: accepted, because the FSM is in IDLE.
- Reset mid-shift: the operation is abandoned and all state returns to reset values.

## Timing
- Reset values: result=0, carry=0, zero=0, sign=0, busy=0, done=0, state IDLE, cnt=0.
- Latency, counting the start-sampling edge as edge 1:
  - non-shift op: `done` high after edge 1
  - shift: `done` high after edge amt+1 (amt=0 ⇒ edge 1)
- `busy` is high from after edge 1 until the edge that asserts `done`; `busy`=0 while `done`=1.
- `done` is high for exactly one cycle per accepted start.
- Throughput: one non-shift op per cycle with back-to-back `start`.

## Structure
- Shared package `kgp_alu_pkg`: `alu_op` constants and the state enum. WIDTH and SHW live there as defaults.
- Sub-module `alu_shift_step`: combinational one-bit shifter with inputs value and mode (SLL/SRL/SRA), outputs next value and the shifted-out bit. It is instantiated once inside the SHIFT datapath.
- Everything else is a single always_ff for FSM, counter and output registers, plus combinational ADD/COMP/AND/XOR.

## Test plan
- Reset mid-shift: SLL a=1, b=31; deassert `rst_n` at edge 5 → all outputs 0 immediately (async). After release, a new ADD completes normally.
- ADD: a=0xFFFFFFFF, b=1, start for 1 cycle → after edge 1, result=0, carry=1, zero=1, sign=0, `done` pulses once, `busy` never high.
- COMP: b=0x00000005 → result=0xFFFFFFFB, sign=1, carry=0. Then COMP with b=0 → result=0, carry=1, zero=1.
- SRA: a=0x80000010, b=4 → `busy` high 4 cycles, `done` after edge 5, result=0xF8000001, carry=0, sign=1. During `busy`, a `start` with ADD is ignored and no extra `done` pulse appears.
- SLL: a=0x80000001, b=0x00000021 (amt=1) → `done` after edge 2, result=0x00000002, carry=1. SRL a=0x1234, b=0 → `done` after edge 1, result=0x1234, carry=0.
- Back-to-back: ADD(3,4), XOR(0xF0,0xFF), undefined op 0xF on consecutive cycles → results 7, 0x0F, 0 on consecutive cycles, three `done` pulses, the last with zero=0.
